// File: rtl/controle_atuadores.sv
// Actuator responder for the irrigation controller: drip/sprinkler FSM with min-on, dead-time and fault hold-off, plus fill valve.
// Optional run-time limit on drip/sprinkler enabled by defining RUNTIME_LIMIT_EN.
module controle_atuadores #(
  parameter int unsigned CW         = 16,
  parameter int unsigned MIN_ON     = 8,
  parameter int unsigned DEAD_T     = 4,
  parameter int unsigned VE_MIN     = 8,
  parameter int unsigned FAULT_HOLD = 16,
  parameter int unsigned MAX_ON     = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GT_REQ,
  input  logic       AS_REQ,
  input  logic       VE_REQ,
  input  logic       AL,
  output logic       GT_ON,
  output logic       AS_ON,
  output logic       VE_ON,
  output logic       BUSY,
  output logic [2:0] ESTADO,
  output logic       TIMEOUT
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GOTEJ = 3'd1,
    ASPER = 3'd2,
    PAUSA = 3'd3,
    FALHA = 3'd4
  } estado_t;

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ve_cnt_q, ve_cnt_d;
  logic          ve_on_d;
  logic          gt_ok, as_ok, run_done;

`ifdef RUNTIME_LIMIT_EN
  logic timeout_q, timeout_d;
  logic to_as_q, to_as_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // State, counters and registered outputs (outputs follow the next state)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ve_cnt_q <= '0;
      GT_ON    <= 1'b0;
      AS_ON    <= 1'b0;
      VE_ON    <= 1'b0;
      BUSY     <= 1'b0;
      ESTADO   <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ve_cnt_q <= ve_cnt_d;
      GT_ON    <= (state_d == GOTEJ);
      AS_ON    <= (state_d == ASPER);
      VE_ON    <= ve_on_d;
      BUSY     <= (state_d != IDLE);
      ESTADO   <= state_d;
    end
  end

`ifdef RUNTIME_LIMIT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      timeout_q <= 1'b0;
      to_as_q   <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      to_as_q   <= to_as_d;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  // Next-state logic; AL overrides everything
  always_comb begin
    state_d  = state_q;
    gt_ok    = GT_REQ;
    as_ok    = AS_REQ;
    run_done = (cnt_q >= CW'(MIN_ON - 1));
`ifdef RUNTIME_LIMIT_EN
    timeout_d = timeout_q;
    to_as_d   = to_as_q;
    if (timeout_q) begin
      if (to_as_q) as_ok = 1'b0;
      else         gt_ok = 1'b0;
      if (!(to_as_q ? AS_REQ : GT_REQ)) timeout_d = 1'b0;
    end
`endif

    case (state_q)
      IDLE: begin
        if (as_ok)      state_d = ASPER;
        else if (gt_ok) state_d = GOTEJ;
      end
      GOTEJ: begin
        if (run_done && (!GT_REQ || as_ok)) state_d = PAUSA;
`ifdef RUNTIME_LIMIT_EN
        if (cnt_q == CW'(MAX_ON - 1)) begin
          state_d   = PAUSA;
          timeout_d = 1'b1;
          to_as_d   = 1'b0;
        end
`endif
      end
      ASPER: begin
        if (run_done && !AS_REQ) state_d = PAUSA;
`ifdef RUNTIME_LIMIT_EN
        if (cnt_q == CW'(MAX_ON - 1)) begin
          state_d   = PAUSA;
          timeout_d = 1'b1;
          to_as_d   = 1'b1;
        end
`endif
      end
      PAUSA: begin
        if (cnt_q == CW'(DEAD_T - 1)) begin
          if (as_ok)      state_d = ASPER;
          else if (gt_ok) state_d = GOTEJ;
          else            state_d = IDLE;
        end
      end
      FALHA: begin
        if (!AL && (cnt_q == CW'(FAULT_HOLD - 1))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (AL) begin
      state_d = FALHA;
`ifdef RUNTIME_LIMIT_EN
      timeout_d = 1'b0;
`endif
    end

    // One shared counter: run time, dead time or fault hold, restarted on every state change
    cnt_d = (AL || (state_d != state_q)) ? '0 : sat_inc(cnt_q);
  end

  // Fill valve: independent of the drip/sprinkler FSM except that a fault forces it off
  always_comb begin
    ve_on_d  = VE_ON;
    ve_cnt_d = ve_cnt_q;
    if (state_d == FALHA) begin
      ve_on_d  = 1'b0;
      ve_cnt_d = '0;
    end else if (!VE_ON) begin
      ve_on_d  = VE_REQ;
      ve_cnt_d = '0;
    end else begin
      ve_cnt_d = sat_inc(ve_cnt_q);
      if (!VE_REQ && (ve_cnt_q >= CW'(VE_MIN - 1))) ve_on_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_atuadores.sv
// Self-checking bench for controle_atuadores: behavioural model compared every cycle plus directed literal checks.
// Define RUNTIME_LIMIT_EN for both bench and RTL to exercise the run-time limit.
module tb_controle_atuadores;

  localparam int unsigned MIN_ON     = 8;
  localparam int unsigned DEAD_T     = 4;
  localparam int unsigned VE_MIN     = 8;
  localparam int unsigned FAULT_HOLD = 16;
  localparam int unsigned MAX_ON     = 20;

  logic       CLK = 1'b0;
  logic       RST, GT_REQ, AS_REQ, VE_REQ, AL;
  logic       GT_ON, AS_ON, VE_ON, BUSY, TIMEOUT;
  logic [2:0] ESTADO;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  controle_atuadores #(
    .CW(16), .MIN_ON(MIN_ON), .DEAD_T(DEAD_T), .VE_MIN(VE_MIN),
    .FAULT_HOLD(FAULT_HOLD), .MAX_ON(MAX_ON)
  ) dut (
    .CLK(CLK), .RST(RST), .GT_REQ(GT_REQ), .AS_REQ(AS_REQ), .VE_REQ(VE_REQ), .AL(AL),
    .GT_ON(GT_ON), .AS_ON(AS_ON), .VE_ON(VE_ON), .BUSY(BUSY), .ESTADO(ESTADO), .TIMEOUT(TIMEOUT)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: which actuator is on and for how long, pause cycles left, quiet cycles in fault
  bit m_gt, m_as, m_ve, m_fault, m_to, m_to_as;
  int run_age, dead_left, quiet, ve_age;

  function automatic int m_estado();
    if (m_fault)       return 4;
    if (m_as)          return 2;
    if (m_gt)          return 1;
    if (dead_left > 0) return 3;
    return 0;
  endfunction

  always @(posedge CLK) begin : model
    bit gt_ok, as_ok, stop;
    if (RST) begin
      m_gt = 0; m_as = 0; m_ve = 0; m_fault = 0; m_to = 0; m_to_as = 0;
      run_age = 0; dead_left = 0; quiet = 0; ve_age = 0;
    end else begin
      gt_ok = GT_REQ;
      as_ok = AS_REQ;
`ifdef RUNTIME_LIMIT_EN
      if (m_to) begin
        if (m_to_as) as_ok = 0; else gt_ok = 0;
        if (!(m_to_as ? AS_REQ : GT_REQ)) m_to = 0;
      end
`endif
      if (AL) begin
        m_fault = 1; quiet = 0; m_gt = 0; m_as = 0; dead_left = 0; m_to = 0;
      end else if (m_fault) begin
        quiet++;
        if (quiet == FAULT_HOLD) m_fault = 0;
      end else if (m_gt || m_as) begin
        stop = (run_age >= MIN_ON) && (m_gt ? (!GT_REQ || as_ok) : !AS_REQ);
`ifdef RUNTIME_LIMIT_EN
        if (run_age == MAX_ON) begin
          stop = 1; m_to = 1; m_to_as = m_as;
        end
`endif
        if (stop) begin
          m_gt = 0; m_as = 0; dead_left = DEAD_T;
        end else run_age++;
      end else if (dead_left > 1) begin
        dead_left--;
      end else begin
        dead_left = 0;
        if (as_ok)      begin m_as = 1; run_age = 1; end
        else if (gt_ok) begin m_gt = 1; run_age = 1; end
      end

      if (m_fault) begin
        m_ve = 0; ve_age = 0;
      end else if (!m_ve) begin
        if (VE_REQ) begin m_ve = 1; ve_age = 1; end
      end else if (!VE_REQ && ve_age >= VE_MIN) m_ve = 0;
      else ve_age++;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cmp_gt_on", GT_ON, m_gt);
      check("cmp_as_on", AS_ON, m_as);
      check("cmp_ve_on", VE_ON, m_ve);
      check("cmp_estado", ESTADO, m_estado());
      check("cmp_busy", BUSY, m_estado() != 0);
      check("cmp_timeout", TIMEOUT, m_to);
      check("cmp_exclusive", GT_ON & AS_ON, 0);
    end
  end

  logic [11:0] vec [10];

  initial begin
    int gt_cnt, p_cnt, seq, prev, gap, k, ve_cnt;
    bit seen_as;
    RST = 1; GT_REQ = 0; AS_REQ = 0; VE_REQ = 0; AL = 0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    check("reset_gt", GT_ON, 0);
    check("reset_estado", ESTADO, 0);
    check("reset_busy", BUSY, 0);
    check("reset_timeout", TIMEOUT, 0);
    RST = 0;
    repeat (2) @(negedge CLK);

    // Short drip request is stretched to the minimum on-time, then dead time
    GT_REQ = 1; seq = 0; prev = ESTADO; gt_cnt = 0; p_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 0) check("gt_latency", GT_ON, 1);
      if (i == 2) GT_REQ = 0;
      gt_cnt += int'(GT_ON);
      if (ESTADO == 3'd3) p_cnt++;
      if (int'(ESTADO) != prev) begin
        seq = seq * 10 + int'(ESTADO);
        prev = int'(ESTADO);
      end
    end
    check("gt_min_on_len", gt_cnt, 8);
    check("pause_len", p_cnt, 4);
    check("estado_seq", seq, 130);

    // Simultaneous requests: sprinkler wins
    GT_REQ = 1; AS_REQ = 1;
    @(negedge CLK);
    check("both_as_on", AS_ON, 1);
    check("both_gt_off", GT_ON, 0);
    check("both_estado", ESTADO, 2);
    GT_REQ = 0; AS_REQ = 0;
    repeat (16) @(negedge CLK);

    // Sprinkler pre-empts a running drip through a dead-time gap
    GT_REQ = 1;
    repeat (10) @(negedge CLK);
    AS_REQ = 1; gap = 0; seen_as = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 0) check("preempt_gt_off", GT_ON, 0);
      if (!seen_as) begin
        if (AS_ON) seen_as = 1;
        else if (!GT_ON) gap++;
      end
    end
    check("preempt_gap", gap, 4);
    check("preempt_as_on", seen_as, 1);
    GT_REQ = 0; AS_REQ = 0;
    repeat (10) @(negedge CLK);

    // Alarm during sprinkler run, then fault hold-off
    AS_REQ = 1; VE_REQ = 1;
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    AL = 1;
    @(negedge CLK);
    check("alarm_as_off", AS_ON, 0);
    check("alarm_ve_off", VE_ON, 0);
    check("alarm_estado", ESTADO, 4);
    AL = 0; AS_REQ = 0; k = 0;
    while (k < 40) begin
      @(negedge CLK);
      k++;
      if (ESTADO == 3'd0) break;
    end
    check("fault_hold_len", k, 16);
    VE_REQ = 0;
    repeat (12) @(negedge CLK);

    // Fill valve pulse stretched to its minimum
    VE_REQ = 1; ve_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      if (i == 1) VE_REQ = 0;
      ve_cnt += int'(VE_ON);
    end
    check("ve_min_len", ve_cnt, 8);

    // Reset in the middle of a run
    GT_REQ = 1; VE_REQ = 1;
    repeat (3) @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    check("rst_gt", GT_ON, 0);
    check("rst_ve", VE_ON, 0);
    check("rst_estado", ESTADO, 0);
    GT_REQ = 0; VE_REQ = 0; RST = 0;
    repeat (3) @(negedge CLK);

`ifdef RUNTIME_LIMIT_EN
    // Run-time limit on a held drip request
    GT_REQ = 1; gt_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      gt_cnt += int'(GT_ON);
    end
    check("limit_gt_len", gt_cnt, 20);
    check("limit_timeout", TIMEOUT, 1);
    check("limit_no_restart", ESTADO, 0);
    GT_REQ = 0;
    @(negedge CLK);
    check("limit_timeout_clr", TIMEOUT, 0);
    repeat (3) @(negedge CLK);
`endif

    // Directed sequence, checked only by the model: {cycles[7:0], al, ve, as, gt}
    vec = '{12'h0C1, 12'h063, 12'h032, 12'h0A0, 12'h022,
            12'h051, 12'h029, 12'h120, 12'h0C5, 12'h140};
    foreach (vec[i]) begin
      {AL, VE_REQ, AS_REQ, GT_REQ} = vec[i][3:0];
      repeat (int'(vec[i][11:4])) @(negedge CLK);
    end
    {AL, VE_REQ, AS_REQ, GT_REQ} = 4'b0000;
    repeat (5) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
